// File: rtl/scc_slot_sequencer.sv
// SCC slot controller: rotates the 6-slot index, owns the channel registers and
// arbitrates the shared wave RAM port between tone fetch and the CPU slot.
module scc_slot_sequencer #(
    parameter logic [7:0] UNMAPPED_RD = 8'hFF
) (
    input  logic        nreset,
    input  logic        clk,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_address,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    output logic [2:0]  active,
    input  logic [4:0]  wave_address,
    output logic [11:0] reg_frequency_count,
    output logic        clear_counter_a,
    output logic        clear_counter_b,
    output logic        clear_counter_c,
    output logic        clear_counter_d,
    output logic        clear_counter_e,
    output logic        reg_wave_reset,
    output logic        reg_wave_error_en,
    output logic [3:0]  volume_a,
    output logic [3:0]  volume_b,
    output logic [3:0]  volume_c,
    output logic [3:0]  volume_d,
    output logic [3:0]  volume_e,
    output logic [4:0]  ch_enable,
    output logic [6:0]  ram_address,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata
);

    typedef enum logic [2:0] {
        SLOT_A   = 3'd0,
        SLOT_B   = 3'd1,
        SLOT_C   = 3'd2,
        SLOT_D   = 3'd3,
        SLOT_E   = 3'd4,
        SLOT_CPU = 3'd5
    } slot_t;

    slot_t       r_slot, w_slot_next;
    logic [11:0] r_freq [5];
    logic [3:0]  r_vol  [5];
    logic [4:0]  r_en;
    logic [7:0]  r_mode;
    logic        r_ack;
    logic        r_rd_wave;
    logic [7:0]  r_rdata;
    logic [4:0]  r_clear;

    logic        w_accept, w_is_wave, w_is_freq, w_is_vol, w_is_en, w_is_mode;
    logic [2:0]  w_fch, w_vch;
    logic [7:0]  w_reg_rdata;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) r_slot <= SLOT_A;
        else         r_slot <= w_slot_next;
    end

    always_comb begin
        w_slot_next = SLOT_A;
        case (r_slot)
            SLOT_A:  w_slot_next = SLOT_B;
            SLOT_B:  w_slot_next = SLOT_C;
            SLOT_C:  w_slot_next = SLOT_D;
            SLOT_D:  w_slot_next = SLOT_E;
            SLOT_E:  w_slot_next = SLOT_CPU;
            default: w_slot_next = SLOT_A;
        endcase
    end

    // Address decode; the channel index of each register group is packed in addr[3:0].
    assign w_is_wave = ~cpu_address[7];
    assign w_is_freq = (cpu_address[7:4] == 4'h8) && (cpu_address[3:0] <= 4'h9);
    assign w_is_vol  = (cpu_address >= 8'h8A) && (cpu_address <= 8'h8E);
    assign w_is_en   = (cpu_address == 8'h8F);
    assign w_is_mode = (cpu_address == 8'hE0);
    assign w_fch     = cpu_address[3:1];
    assign w_vch     = cpu_address[2:0] - 3'd2;
    assign w_accept  = (r_slot == SLOT_CPU) && cpu_req && !r_ack;

    always_comb begin
        w_reg_rdata = UNMAPPED_RD;
        if (w_is_freq)
            w_reg_rdata = cpu_address[0] ? {4'h0, r_freq[w_fch][11:8]} : r_freq[w_fch][7:0];
        else if (w_is_vol)
            w_reg_rdata = {4'h0, r_vol[w_vch]};
        else if (w_is_en)
            w_reg_rdata = {3'b000, r_en};
        else if (w_is_mode)
            w_reg_rdata = r_mode;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int unsigned i = 0; i < 5; i++) begin
                r_freq[i] <= '0;
                r_vol[i]  <= '0;
            end
            r_en      <= '0;
            r_mode    <= '0;
            r_ack     <= 1'b0;
            r_rd_wave <= 1'b0;
            r_rdata   <= '0;
            r_clear   <= '0;
        end else begin
            r_ack   <= w_accept;
            r_clear <= (w_accept && cpu_wr && w_is_freq) ? (5'b00001 << w_fch) : '0;
            if (w_accept) begin
                r_rd_wave <= w_is_wave && !cpu_wr;
                r_rdata   <= w_reg_rdata;
                if (cpu_wr) begin
                    if (w_is_freq) begin
                        if (cpu_address[0]) r_freq[w_fch][11:8] <= cpu_wdata[3:0];
                        else                r_freq[w_fch][7:0]  <= cpu_wdata;
                    end
                    if (w_is_vol)  r_vol[w_vch] <= cpu_wdata[3:0];
                    if (w_is_en)   r_en         <= cpu_wdata[4:0];
                    if (w_is_mode) r_mode       <= cpu_wdata;
                end
            end
        end
    end

    // Wave reads come straight from the RAM, whose one-cycle latency lands on the ack slot.
    assign cpu_ack   = r_ack;
    assign cpu_rdata = r_ack ? (r_rd_wave ? ram_rdata : r_rdata) : '0;
    assign active    = r_slot;

    always_comb begin
        reg_frequency_count = '0;
        ram_address         = {r_slot[1:0], wave_address};
        case (r_slot)
            SLOT_A:   reg_frequency_count = r_freq[0];
            SLOT_B:   reg_frequency_count = r_freq[1];
            SLOT_C:   reg_frequency_count = r_freq[2];
            SLOT_D:   reg_frequency_count = r_freq[3];
            SLOT_E: begin
                reg_frequency_count = r_freq[4];
                ram_address         = {2'd3, wave_address};
            end
            default:  ram_address   = cpu_address[6:0];
        endcase
    end

    assign ram_we    = w_accept && cpu_wr && w_is_wave;
    assign ram_wdata = cpu_wdata;

    assign clear_counter_a   = r_clear[0];
    assign clear_counter_b   = r_clear[1];
    assign clear_counter_c   = r_clear[2];
    assign clear_counter_d   = r_clear[3];
    assign clear_counter_e   = r_clear[4];
    assign volume_a          = r_vol[0];
    assign volume_b          = r_vol[1];
    assign volume_c          = r_vol[2];
    assign volume_d          = r_vol[3];
    assign volume_e          = r_vol[4];
    assign ch_enable         = r_en;
    assign reg_wave_reset    = r_mode[5];
    assign reg_wave_error_en = r_mode[0];

endmodule

// File: tb/tb_scc_slot_sequencer.sv
// Scoreboard bench for scc_slot_sequencer: a driver queues expected CPU responses from a
// register/RAM reference model; a negedge monitor pops them on cpu_ack and checks all outputs.
module tb_scc_slot_sequencer;

    logic        nreset, clk;
    logic        cpu_req, cpu_wr, cpu_ack;
    logic [7:0]  cpu_address, cpu_wdata, cpu_rdata;
    logic [2:0]  active;
    logic [4:0]  wave_address;
    logic [11:0] reg_frequency_count;
    logic        clear_counter_a, clear_counter_b, clear_counter_c, clear_counter_d, clear_counter_e;
    logic        reg_wave_reset, reg_wave_error_en;
    logic [3:0]  volume_a, volume_b, volume_c, volume_d, volume_e;
    logic [4:0]  ch_enable;
    logic [6:0]  ram_address;
    logic        ram_we;
    logic [7:0]  ram_wdata, ram_rdata;

    scc_slot_sequencer #(.UNMAPPED_RD(8'hFF)) dut (
        .nreset(nreset), .clk(clk),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_address(cpu_address), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .active(active), .wave_address(wave_address),
        .reg_frequency_count(reg_frequency_count),
        .clear_counter_a(clear_counter_a), .clear_counter_b(clear_counter_b),
        .clear_counter_c(clear_counter_c), .clear_counter_d(clear_counter_d),
        .clear_counter_e(clear_counter_e),
        .reg_wave_reset(reg_wave_reset), .reg_wave_error_en(reg_wave_error_en),
        .volume_a(volume_a), .volume_b(volume_b), .volume_c(volume_c),
        .volume_d(volume_d), .volume_e(volume_e), .ch_enable(ch_enable),
        .ram_address(ram_address), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wave RAM environment with one-cycle read latency.
    logic [7:0] ram [128];
    always @(posedge clk) begin
        if (ram_we) ram[ram_address] <= ram_wdata;
        ram_rdata <= ram[ram_address];
    end

    always @(posedge clk) begin
        #1 wave_address = 5'($urandom);
    end

    // Bench-owned cycle count since reset release: the slot is simply cyc mod 6.
    int cyc;
    always @(posedge clk or negedge nreset) begin
        if (!nreset) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    // Reference model
    int mfreq [5];
    int mvol [5];
    int men, mmode;
    int mwave [128];

    typedef struct {
        bit wr;
        int addr;
        int data;
        int exp_rdata;
        int exp_ack;
    } txn_t;
    txn_t sb [$];

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int model_read(input int a);
        if (a < 128)                 return mwave[a];
        if (a >= 'h80 && a <= 'h89)  return ((a - 'h80) % 2 == 0) ? (mfreq[(a - 'h80) / 2] & 'hFF)
                                                                   : (mfreq[(a - 'h80) / 2] >> 8);
        if (a >= 'h8A && a <= 'h8E)  return mvol[a - 'h8A];
        if (a == 'h8F)               return men;
        if (a == 'hE0)               return mmode;
        return 'hFF;
    endfunction

    function automatic int model_write(input int a, input int d);
        int n;
        n = -1;
        if (a < 128) mwave[a] = d;
        else if (a >= 'h80 && a <= 'h89) begin
            n = (a - 'h80) / 2;
            if ((a - 'h80) % 2 == 0) mfreq[n] = (mfreq[n] & 'hF00) | d;
            else                     mfreq[n] = (mfreq[n] & 'h0FF) | ((d & 'hF) << 8);
        end
        else if (a >= 'h8A && a <= 'h8E) mvol[a - 'h8A] = d & 'hF;
        else if (a == 'h8F)              men = d & 'h1F;
        else if (a == 'hE0)              mmode = d;
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 5; i++) begin
            mfreq[i] = 0;
            mvol[i] = 0;
        end
        men = 0;
        mmode = 0;
        sb.delete();
    endtask

    task automatic check_regs(input int exp_clear);
        int slot;
        slot = cyc % 6;
        chk("reg_frequency_count", reg_frequency_count, (slot < 5) ? mfreq[slot] : 0);
        chk("clear_counter", {clear_counter_e, clear_counter_d, clear_counter_c,
                              clear_counter_b, clear_counter_a}, exp_clear);
        chk("volume", {volume_e, volume_d, volume_c, volume_b, volume_a},
            (mvol[4] << 16) | (mvol[3] << 12) | (mvol[2] << 8) | (mvol[1] << 4) | mvol[0]);
        chk("ch_enable", ch_enable, men);
        chk("mode_bits", {reg_wave_reset, reg_wave_error_en}, {((mmode >> 5) & 1) != 0, (mmode & 1) != 0});
    endtask

    // Monitor
    always @(negedge clk) begin
        int slot, exp_clear, n, exp_ra;
        txn_t e;
        if (mon_en && nreset) begin
            slot = cyc % 6;
            exp_clear = 0;
            chk("active", active, slot);
            if (cpu_ack) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("ack_cycle", cyc, e.exp_ack);
                    if (e.wr) begin
                        n = model_write(e.addr, e.data);
                        if (n >= 0) exp_clear = 1 << n;
                    end else begin
                        chk($sformatf("rdata@%0h", e.addr), cpu_rdata, e.exp_rdata);
                    end
                end
            end
            check_regs(exp_clear);
            if (slot < 4)       exp_ra = slot * 32 + wave_address;
            else if (slot == 4) exp_ra = 96 + wave_address;
            else                exp_ra = cpu_address & 'h7F;
            chk("ram_address", ram_address, exp_ra);
            chk("ram_we", ram_we, (slot == 5 && cpu_req && cpu_wr && cpu_address < 128) ? 1 : 0);
            if (ram_we) chk("ram_wdata", ram_wdata, cpu_wdata);
        end
    end

    task automatic do_txn(input bit wr, input int addr, input int data, input int at_slot);
        txn_t e;
        int c;
        bit got;
        repeat ($urandom_range(1, 7)) begin
            @(posedge clk); #1;
        end
        if (at_slot >= 0) begin
            while (cyc % 6 != at_slot) begin
                @(posedge clk); #1;
            end
        end
        c = cyc;
        while (c % 6 != 5) c++;
        e.wr = wr;
        e.addr = addr;
        e.data = data;
        e.exp_rdata = wr ? 0 : model_read(addr);
        e.exp_ack = c + 1;
        sb.push_back(e);
        cpu_wr = wr;
        cpu_address = 8'(addr);
        cpu_wdata = 8'(data);
        cpu_req = 1'b1;
        got = 0;
        for (int k = 0; k < 12 && !got; k++) begin
            @(posedge clk); #1;
            if (cpu_ack) got = 1;
        end
        if (!got) begin
            chk("ack_timeout", 0, 1);
            sb.delete();
        end
        cpu_req = 1'b0;
    endtask

    function automatic int rand_addr();
        int u[4];
        u = '{'h90, 'hA5, 'hE1, 'hFF};
        case ($urandom_range(0, 5))
            0, 1:    return 'h60 + $urandom_range(0, 7);
            2:       return 'h80 + $urandom_range(0, 9);
            3:       return 'h8A + $urandom_range(0, 5);
            4:       return 'hE0;
            default: return u[$urandom_range(0, 3)];
        endcase
    endfunction

    initial begin
        int a;
        nreset = 1'b0;
        cpu_req = 1'b0;
        cpu_wr = 1'b0;
        cpu_address = 8'h00;
        cpu_wdata = 8'h00;
        wave_address = 5'd0;
        for (int i = 0; i < 128; i++) begin
            ram[i] = 8'($urandom);
            mwave[i] = ram[i];
        end
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_active", active, 0);
        chk("rst_ack", cpu_ack, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_freq", reg_frequency_count, 0);
        nreset = 1'b1;
        mon_en = 1;

        do_txn(1, 'h81, 'h0A, -1);
        do_txn(1, 'h80, 'h34, -1);
        do_txn(1, 'h8C, 'h07, 1);
        do_txn(1, 'h65, 'h7F, -1);
        do_txn(0, 'h65, 0, 0);
        do_txn(0, 'h90, 0, 5);
        do_txn(1, 'h8F, 'hFF, -1);
        do_txn(1, 'hE0, 'h21, -1);
        do_txn(1, 'h89, 'hF5, 4);
        for (int i = 0; i < 60; i++) begin
            a = rand_addr();
            do_txn($urandom_range(0, 1) == 1, a, $urandom_range(0, 255), -1);
        end

        // Reset during a pending read: assert between accept and ack.
        mon_en = 0;
        repeat (2) begin @(posedge clk); #1; end
        while (cyc % 6 != 2) begin @(posedge clk); #1; end
        cpu_wr = 1'b0;
        cpu_address = 8'h65;
        cpu_req = 1'b1;
        while (cyc % 6 != 5) begin @(posedge clk); #1; end
        #2 nreset = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_mid_ack", cpu_ack, 0);
            chk("rst_mid_active", active, 0);
        end
        check_regs(0);
        cpu_req = 1'b0;
        nreset = 1'b1;
        mon_en = 1;
        for (int i = 0; i < 12; i++) begin
            a = rand_addr();
            do_txn($urandom_range(0, 1) == 1, a, $urandom_range(0, 255), -1);
        end
        repeat (8) @(posedge clk);
        if (sb.size() != 0) chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
